// File: rtl/gray_seq_ctrl.sv
// Gray-code sequencer: walks a binary counter up or down from a programmed
// start value for a programmed number of steps, emitting each Gray code on a
// valid/ready handshake.
module gray_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             xfer;

  // Handshake: a code is transferred on every rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low the
  // code is held stable. out_valid never drops without a transfer except on abort.
  assign xfer = out_valid && out_ready;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (xfer && rem_q <= LEN_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Counter, remaining-count and direction updates
  always_comb begin
    bin_d = bin_q;
    rem_d = rem_q;
    dir_d = dir_q;
    if (abort) begin
      rem_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bin_d = start_val;
            rem_d = len;
            dir_d = dir;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (rem_q > LEN_W'(1)) begin
              rem_d = rem_q - LEN_W'(1);
              bin_d = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
            end else begin
              rem_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state so they are glitch-free and aligned
  always_comb begin
    out_valid = (state_q == S_RUN);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    bin_out   = bin_q;
    gray_out  = bin_q ^ (bin_q >> 1);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl: vector table, hand-written corner
// sequences, and randomized sequences against a transaction-level model.
module tb_gray_seq_ctrl;
  localparam int W = 4;
  localparam int L = 8;

  logic         clk, rst_n, start, dir, abort, out_ready;
  logic [W-1:0] start_val;
  logic [L-1:0] len;
  logic         out_valid, busy, done;
  logic [W-1:0] gray_out, bin_out;
  logic [1:0]   state_dbg;

  int n_pass = 0;
  int n_total = 0;

  gray_seq_ctrl #(.WIDTH(W), .LEN_W(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .start_val(start_val),
    .len(len), .abort(abort), .out_ready(out_ready), .out_valid(out_valid),
    .gray_out(gray_out), .bin_out(bin_out), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] sv;
    logic [L-1:0] len;
    logic         dir;
    logic [15:0]  gcodes;  // expected codes, first in the top nibble
  } vec_t;

  vec_t vecs [5];

  // Scoreboard expected queue of binary values
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Advance one clock; inputs and samples both happen 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; dir = 1'b0; start_val = '0; len = '0; abort = 1'b0;
  endtask

  task automatic do_start(input logic [W-1:0] sv, input logic [L-1:0] n, input logic d);
    start = 1'b1; start_val = sv; len = n; dir = d;
    tick();
    start = 1'b0;
  endtask

  // Run one table vector with out_ready held high
  task automatic run_vec(input vec_t v);
    out_ready = 1'b1;
    do_start(v.sv, v.len, v.dir);
    for (int i = 0; i < int'(v.len); i++) begin
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_gray", 32'(gray_out), 32'(v.gcodes[15-4*i -: 4]));
      tick();
    end
    chk("vec_done", 32'(done), 32'd1);
    chk("vec_valid_off", 32'(out_valid), 32'd0);
    tick();
    chk("vec_done_pulse", 32'(done), 32'd0);
    chk("vec_idle", 32'(busy), 32'd0);
  endtask

  // Randomized sequence checked against a queue of expected binary values
  task automatic run_random();
    logic [W-1:0] sv;
    logic [L-1:0] n;
    logic         d;
    logic         seen_done;
    int           step;
    sv = W'($urandom_range(0, 15));
    n  = L'($urandom_range(0, 6));
    d  = 1'($urandom_range(0, 1));
    step = d ? -1 : 1;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++)
      exp_q.push_back(W'(((int'(sv) + step * i) % 16 + 16) % 16));
    do_start(sv, n, d);
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done) begin
        chk("rnd_done_empty", 32'(exp_q.size()), 32'd0);
        seen_done = 1'b1;
        break;
      end
      chk("rnd_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      // mid-sequence noise on the command inputs must be ignored
      out_ready = ($urandom_range(0, 3) != 0);
      start     = 1'($urandom_range(0, 1));
      start_val = W'($urandom_range(0, 15));
      len       = L'($urandom_range(0, 9));
      dir       = 1'($urandom_range(0, 1));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("rnd_bin", 32'(bin_out), 32'(e));
        chk("rnd_gray", 32'(gray_out), 32'(to_gray(e)));
      end
      tick();
    end
    chk("rnd_seen_done", 32'(seen_done), 32'd1);
    idle_inputs();
    tick();
    chk("rnd_back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{sv: 4'd6,  len: 8'd3, dir: 1'b0, gcodes: 16'h54C0};
    vecs[1] = '{sv: 4'd14, len: 8'd4, dir: 1'b0, gcodes: 16'h9801};
    vecs[2] = '{sv: 4'd1,  len: 8'd3, dir: 1'b1, gcodes: 16'h1080};
    vecs[3] = '{sv: 4'd0,  len: 8'd2, dir: 1'b1, gcodes: 16'h0800};
    vecs[4] = '{sv: 4'd5,  len: 8'd1, dir: 1'b0, gcodes: 16'h7000};

    idle_inputs();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_gray", 32'(gray_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Down wrap with backpressure: code held while stalled
    out_ready = 1'b0;
    do_start(4'd1, 8'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_gray", 32'(gray_out), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_gray0", 32'(gray_out), 32'h1); tick();
    chk("bp_gray1", 32'(gray_out), 32'h0); tick();
    chk("bp_gray2", 32'(gray_out), 32'h8); tick();
    chk("bp_done", 32'(done), 32'd1);
    tick();
    chk("bp_done_once", 32'(done), 32'd0);

    // Zero length: no codes, single-cycle busy/done
    do_start(4'd3, 8'd0, 1'b0);
    chk("zl_valid", 32'(out_valid), 32'd0);
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_busy", 32'(busy), 32'd1);
    tick();
    chk("zl_done_off", 32'(done), 32'd0);
    chk("zl_busy_off", 32'(busy), 32'd0);
    chk("zl_valid_off", 32'(out_valid), 32'd0);

    // Abort after two transfers, with a third transfer on the abort cycle
    out_ready = 1'b1;
    do_start(4'd0, 8'd10, 1'b0);
    chk("ab_bin0", 32'(bin_out), 32'd0); tick();
    chk("ab_bin1", 32'(bin_out), 32'd1); tick();
    chk("ab_bin2", 32'(bin_out), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", 32'(out_valid), 32'd0);
    chk("ab_state", 32'(state_dbg), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_bin_hold", 32'(bin_out), 32'd2);
    do_start(4'd3, 8'd1, 1'b0);
    chk("ab_restart_valid", 32'(out_valid), 32'd1);
    chk("ab_restart_bin", 32'(bin_out), 32'd3);
    tick();
    chk("ab_restart_done", 32'(done), 32'd1);
    tick();

    // Asynchronous reset mid-run
    do_start(4'd9, 8'd5, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_bin", 32'(bin_out), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_no_done", 32'(done), 32'd0);
    run_vec(vecs[0]);

    for (int k = 0; k < 25; k++) run_random();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
